mse_loss_unit: RTL and testbench
================================

Name: mse_loss_unit

Overview:
- Sequential loss stage directly downstream of the fully connected layer's forward output.
- Accepts one predicted vector (the layer's output_data) plus a target vector through a valid/ready handshake.
- Produces the per-element error vector that feeds the layer's output_error input, plus a scalar sum-of-squared-error loss.
- Processes one element per cycle with a single shared multiplier.
- All arithmetic is signed fixed point with FIXED_POINT_INDEX fraction bits.

Parameters:
- WIDTH, 32, data word width in bits.
- OUTPUT_DIM, 4, vector length; must be at least 1.
- FIXED_POINT_INDEX, 16, number of fraction bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  predicted and target vectors are valid.
- in_ready  output  1  block can accept a new vector pair.
- predicted  input  signed WIDTH x [OUTPUT_DIM]  layer forward output.
- target  input  signed WIDTH x [OUTPUT_DIM]  desired output.
- out_valid  output  1  output_error and loss are complete.
- out_ready  input  1  downstream consumes the result.
- output_error  output  signed WIDTH x [OUTPUT_DIM]  target minus predicted, per element.
- loss  output  signed WIDTH  saturated sum of squared errors.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high, or immediately on its assertion:
  - State goes to IDLE and the element index goes to 0.
  - Captured input registers, output_error[*] and loss all go to 0.
  - out_valid=0, in_ready=1 (in_ready is derived from state).
- FSM states IDLE, COMPUTE, DONE:
  - in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state, with no combinational path from the inputs.
  - IDLE: on an edge with in_valid=1, copy predicted and target into internal registers, zero the loss accumulator, set idx=0, go to COMPUTE. Without in_valid, stay in IDLE.
  - COMPUTE: each edge processes element idx:
    - e = target[idx] − predicted[idx], WIDTH-bit two's-complement, wrapping with no saturation; written to output_error[idx].
    - sq = (e*e computed at 2*WIDTH bits) >>> FIXED_POINT_INDEX; if sq exceeds 2^(WIDTH-1)−1, clamp to 2^(WIDTH-1)−1.
    - loss = loss + sq, clamped to 2^(WIDTH-1)−1 on overflow. The accumulator is never negative.
    - idx increments. On the edge that processes idx=OUTPUT_DIM−1, go to DONE.
  - DONE: output_error and loss hold. On an edge with out_ready=1, go to IDLE; outputs keep their values after the transition.
- Latency and throughput:
  - With acceptance at edge k, out_valid rises after edge k+OUTPUT_DIM.
  - With out_ready held high, out_valid is a single cycle.
  - Best-case spacing between acceptances is OUTPUT_DIM+2 cycles.
- Upstream inputs may change freely after acceptance; only the captured copies are used.
- in_valid is ignored outside IDLE; nothing is captured and nothing is lost silently, because in_ready is low.
- output_error and loss are meaningful only while out_valid=1. They change progressively during COMPUTE.
- Reset asserted mid-COMPUTE or mid-DONE aborts the transaction with no partial result retained. The first cycle after reset release accepts a new transaction normally.
- OUTPUT_DIM=1: COMPUTE lasts exactly one edge.

Test Plan:
- Basic (Q16.16, OUTPUT_DIM=4): predicted {0x00010000, 0, 0xFFFF8000, 0x00020000}, target {0x00018000, 0, 0x00008000, 0x00020000}.
  - output_error = {0x00008000, 0, 0x00010000, 0}, loss = 0x00014000.
  - out_valid rises exactly 4 edges after acceptance.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and drive a different vector pair with in_valid=1 meanwhile.
  - out_valid and outputs stay constant, in_ready=0, the new pair is not captured.
  - The pair is accepted the cycle after the out_ready handshake returns the FSM to IDLE.
- Saturation: all errors 0x00C80000 (200.0). Each square exceeds the range, so loss = 0x7FFFFFFF.
  - Also errors 0x00B50000 (181.0) ×4: each square 32761.0 = 0x7FF90000 fits, but the sum clamps, so loss = 0x7FFFFFFF.
- Error wrap: target 0x7FFFFFFF, predicted 0xFFFFFFFF → output_error 0x80000000 (wrapped), and its square clamps.
- Reset mid-operation: pulse rst asynchronously (between clock edges) after 2 COMPUTE edges.
  - All outputs read 0 immediately, out_valid=0, in_ready=1.
  - A subsequent basic transaction produces the basic-case values exactly.
- Back-to-back: in_valid and out_ready held at 1 with three distinct vector pairs.
  - Acceptances are spaced exactly OUTPUT_DIM+2=6 cycles apart, each result correct and unaffected by the previous loss accumulation.

Source files
------------

// File: rtl/mse_loss_unit.sv
// Mean-squared-error loss stage. Accepts a predicted/target vector pair,
// walks the elements one per cycle through a single shared squarer, and
// presents the per-element error (target - predicted) plus the saturated
// sum of squared errors in signed fixed point.

// Squares one signed fixed-point error and rescales it back to the input
// format. The square is never negative, so only the upper bound is clamped.
module mse_sq_sat #(
  parameter int WIDTH             = 32,
  parameter int FIXED_POINT_INDEX = 16
) (
  input  logic signed [WIDTH-1:0] err,
  output logic        [WIDTH-1:0] sq
);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MAX_W =
    {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;

  assign prod    = err * err;
  assign shifted = prod >>> FIXED_POINT_INDEX;
  assign sq      = (shifted > MAX_W) ? MAX_POS : shifted[WIDTH-1:0];
endmodule

module mse_loss_unit #(
  parameter int WIDTH             = 32,
  parameter int OUTPUT_DIM        = 4,
  parameter int FIXED_POINT_INDEX = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [OUTPUT_DIM-1:0][WIDTH-1:0] predicted,
  input  logic signed [OUTPUT_DIM-1:0][WIDTH-1:0] target,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [OUTPUT_DIM-1:0][WIDTH-1:0] output_error,
  output logic signed [WIDTH-1:0]               loss
);
  localparam int IDX_W = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_DIM - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                            state, state_nxt;
  logic [IDX_W-1:0]                  idx;
  logic [OUTPUT_DIM-1:0][WIDTH-1:0]  pred_q, tgt_q;
  logic [WIDTH-1:0]                  err_cur;
  logic [WIDTH-1:0]                  sq_cur;
  logic [WIDTH:0]                    acc_sum;
  logic                              last;

  // Handshake flags come straight from the state register.
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last = (idx == LAST_IDX);

  // Error wraps in WIDTH bits by design; no saturation on the subtraction.
  assign err_cur = tgt_q[idx] - pred_q[idx];

  mse_sq_sat #(
    .WIDTH             (WIDTH),
    .FIXED_POINT_INDEX (FIXED_POINT_INDEX)
  ) u_sq (
    .err (signed'(err_cur)),
    .sq  (sq_cur)
  );

  // Both addends are within [0, MAX_POS], so one extra bit holds the sum.
  assign acc_sum = {1'b0, loss} + {1'b0, sq_cur};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = COMPUTE;
      COMPUTE: if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Capture on accept, then accumulate one element per COMPUTE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      pred_q       <= '0;
      tgt_q        <= '0;
      output_error <= '0;
      loss         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          pred_q <= predicted;
          tgt_q  <= target;
          loss   <= '0;
          idx    <= '0;
        end
        COMPUTE: begin
          output_error[idx] <= err_cur;
          loss <= (acc_sum > {1'b0, MAX_POS}) ? MAX_POS : acc_sum[WIDTH-1:0];
          idx  <= last ? '0 : idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mse_loss_unit.sv
// Directed bench for mse_loss_unit at default parameters (Q16.16, 4 elements).
module tb_mse_loss_unit;
  typedef logic [31:0] vec_t [4];

  logic             clk = 0;
  logic             rst = 1;
  logic             in_valid = 0;
  logic             in_ready;
  logic [3:0][31:0] predicted = '0;
  logic [3:0][31:0] target = '0;
  logic             out_valid;
  logic             out_ready = 0;
  logic [3:0][31:0] output_error;
  logic [31:0]      loss;

  int total = 0;
  int bad = 0;

  mse_loss_unit #(.WIDTH(32), .OUTPUT_DIM(4), .FIXED_POINT_INDEX(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .predicted    (predicted),
    .target       (target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .output_error (output_error),
    .loss         (loss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input vec_t p, input vec_t t);
    for (int i = 0; i < 4; i++) begin
      predicted[i] = p[i];
      target[i]    = t[i];
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < 4; i++) begin
      predicted[i] = 32'h1234_5678 + i;
      target[i]    = 32'hCAFE_0000 - i;
    end
  endtask

  task automatic chk_res(input string tag, input vec_t e, input logic [31:0] l);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_err%0d", tag, i), output_error[i], e[i]);
    chk({tag, "_loss"}, loss, l);
  endtask

  // Waits out the compute phase after an acceptance edge; out_valid must
  // first be seen at the 5th falling edge (i.e. right after edge k+4).
  task automatic wait_done(input string tag);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 20);
    chk({tag, "_lat"}, cnt, 5);
  endtask

  task automatic run_txn(input string tag, input vec_t p, input vec_t t,
                         input vec_t e, input logic [31:0] l, input bit rel);
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    drive(p, t);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    scramble();
    wait_done(tag);
    chk_res(tag, e, l);
    if (rel) begin
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk({tag, "_vld_drop"}, out_valid, 0);
      chk({tag, "_loss_hold"}, loss, l);
    end
  endtask

  vec_t z  = '{32'h0, 32'h0, 32'h0, 32'h0};
  vec_t pa = '{32'h00010000, 32'h0, 32'hFFFF8000, 32'h00020000};
  vec_t ta = '{32'h00018000, 32'h0, 32'h00008000, 32'h00020000};
  vec_t ea = '{32'h00008000, 32'h0, 32'h00010000, 32'h0};
  vec_t pb = '{32'h0, 32'h00010000, 32'h0, 32'h0};
  vec_t tb = '{32'h00020000, 32'h0, 32'h0, 32'hFFFF0000};
  vec_t eb = '{32'h00020000, 32'hFFFF0000, 32'h0, 32'hFFFF0000};
  vec_t tc = '{32'h00030000, 32'h0, 32'h0, 32'h0};
  vec_t s200 = '{32'h00C80000, 32'h00C80000, 32'h00C80000, 32'h00C80000};
  vec_t s181 = '{32'h00B50000, 32'h00B50000, 32'h00B50000, 32'h00B50000};
  vec_t tw = '{32'h7FFFFFFF, 32'h0, 32'h0, 32'h0};
  vec_t pw = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
  vec_t ew = '{32'h80000000, 32'h0, 32'h0, 32'h0};

  initial begin
    vec_t bp[3], bt[3], be[3];
    logic [31:0] bl[3];
    int acc_cyc[3];
    int acc_n, res_n, cyc;

    // Reset state
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_loss", loss, 0);
    chk("rst_err0", output_error[0], 0);
    #12 rst = 0;

    // Basic vector and saturation / wrap cases
    run_txn("basic", pa, ta, ea, 32'h00014000, 1);
    run_txn("sat200", z, s200, s200, 32'h7FFFFFFF, 1);
    run_txn("sat181", z, s181, s181, 32'h7FFFFFFF, 1);
    run_txn("wrap", pw, tw, ew, 32'h7FFFFFFF, 1);

    // Backpressure: results hold and a new pair waits for IDLE
    run_txn("bp", pa, ta, ea, 32'h00014000, 0);
    drive(pb, tb);
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      chk("bp_loss", loss, 32'h00014000);
      chk("bp_err2", output_error[2], 32'h00010000);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp_idle", in_ready, 1);
    chk("bp_keep", loss, 32'h00014000);
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp_acc", in_ready, 0);
    wait_done("bp2");
    chk_res("bp2", eb, 32'h00060000);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;

    // Asynchronous reset two COMPUTE edges into a transaction
    @(negedge clk);
    drive(pa, ta);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_loss", loss, 0);
    chk("mid_rst_err0", output_error[0], 0);
    #1 rst = 0;
    run_txn("post_rst", pa, ta, ea, 32'h00014000, 1);

    // Back-to-back with both handshakes held high
    bp[0] = pa; bt[0] = ta; be[0] = ea; bl[0] = 32'h00014000;
    bp[1] = z;  bt[1] = tc; be[1] = tc; bl[1] = 32'h00090000;
    bp[2] = pb; bt[2] = tb; be[2] = eb; bl[2] = 32'h00060000;
    acc_n = 0; res_n = 0; cyc = 0;
    out_ready = 1;
    while (res_n < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk_res($sformatf("b2b%0d", res_n), be[res_n], bl[res_n]);
        res_n++;
      end
      if (in_ready) begin
        if (acc_n < 3) begin
          drive(bp[acc_n], bt[acc_n]);
          in_valid = 1;
          acc_cyc[acc_n] = cyc;
          acc_n++;
        end else in_valid = 0;
      end
    end
    in_valid = 0;
    chk("b2b_count", res_n, 3);
    chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 6);
    chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 6);
    @(negedge clk);
    out_ready = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
